// File: rtl/assoc_cache_if.sv
// Core request/response and backing-memory bus bundle
// shared by assoc_cache and whatever drives it.
interface assoc_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              miss;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_rdata, miss,
        output mem_req_valid, mem_req_write,
        output mem_req_addr, mem_req_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_rdata, miss,
        input  mem_req_valid, mem_req_write,
        input  mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-through cache with
// true-LRU replacement and block fill on read miss.
module assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8
) (
    input logic          clk,
    input logic          rst,
    assoc_cache_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int WI_W  = $clog2(WORDS);
    localparam int SI_W  = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - WI_W - SI_W;
    localparam int WIB   = (WI_W > 0) ? WI_W : 1;
    localparam int SIB   = (SI_W > 0) ? SI_W : 1;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [ADDR_W-1:0] WMASK = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] SMASK = ADDR_W'(SETS - 1);
    localparam logic [ADDR_W-1:0] OMASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] BMASK =
        ADDR_W'(WORDS * BYTES - 1);
    localparam logic [WIB-1:0]   LAST  = WIB'(WORDS - 1);
    localparam logic [WAY_W-1:0] OLD   = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL_REQ,
        FILL_WAIT,
        FILL_DONE,
        WR_MEM,
        RESP
    } state_t;

    function automatic logic [WIB-1:0] wordOf(
        input logic [ADDR_W-1:0] a
    );
        return WIB'((a >> OFF_W) & WMASK);
    endfunction

    function automatic logic [SIB-1:0] setOf(
        input logic [ADDR_W-1:0] a
    );
        return SIB'((a >> (OFF_W + WI_W)) & SMASK);
    endfunction

    function automatic logic [TAG_W-1:0] tagOf(
        input logic [ADDR_W-1:0] a
    );
        return TAG_W'(a >> (OFF_W + WI_W + SI_W));
    endfunction

    logic [DATA_W-1:0] dataArr  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tagArr   [WAYS][SETS];
    logic [WAYS-1:0]   validArr [SETS];
    logic [WAY_W-1:0]  ageArr   [SETS][WAYS];

    state_t            state;
    state_t            stateN;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] respQ;
    logic [WAY_W-1:0]  victimQ;
    logic [WIB-1:0]    cntQ;

    logic              accept;
    logic              hit;
    logic [WAY_W-1:0]  hitWay;
    logic [WAY_W-1:0]  victim;
    logic [DATA_W-1:0] hitWord;
    logic [SIB-1:0]    reqSet;
    logic [WIB-1:0]    reqWord;
    logic [TAG_W-1:0]  reqTag;
    logic [SIB-1:0]    setQ;
    logic [WIB-1:0]    wordQ;
    logic [ADDR_W-1:0] fillAddr;
    logic [ADDR_W-1:0] wordAddr;
    logic              fillBeat;
    logic              lruEn;
    logic [SIB-1:0]    lruSet;
    logic [WAY_W-1:0]  lruWay;

    assign reqSet   = setOf(bus.req_addr);
    assign reqWord  = wordOf(bus.req_addr);
    assign reqTag   = tagOf(bus.req_addr);
    assign setQ     = setOf(addrQ);
    assign wordQ    = wordOf(addrQ);
    assign fillAddr = (addrQ & ~BMASK)
                    | (ADDR_W'(cntQ) << OFF_W);
    assign wordAddr = addrQ & ~OMASK;

    assign accept   = bus.req_valid & bus.req_ready;
    assign fillBeat = (state == FILL_WAIT)
                    & bus.mem_resp_valid;

    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (validArr[reqSet][w] &&
                tagArr[w][reqSet] == reqTag) begin
                hit    = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
    end

    assign hitWord = dataArr[hitWay][reqSet][reqWord];

    // Oldest way is the fallback; any invalid way overrides it,
    // scanning downwards so the lowest index wins.
    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ageArr[reqSet][w] == OLD) victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validArr[reqSet][w]) victim = WAY_W'(w);
        end
    end

    always_comb begin
        stateN = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_write) stateN = WR_MEM;
                    else if (hit)      stateN = RESP;
                    else               stateN = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (bus.mem_req_ready) stateN = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.mem_resp_valid) begin
                    stateN = (cntQ == LAST) ? FILL_DONE
                                            : FILL_REQ;
                end
            end
            FILL_DONE: stateN = RESP;
            WR_MEM: begin
                if (bus.mem_req_ready) stateN = RESP;
            end
            RESP:    stateN = IDLE;
            default: stateN = IDLE;
        endcase
    end

    assign lruEn  = (accept & hit) | (state == FILL_DONE);
    assign lruSet = (state == FILL_DONE) ? setQ : reqSet;
    assign lruWay = (state == FILL_DONE) ? victimQ : hitWay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addrQ   <= '0;
            wdataQ  <= '0;
            respQ   <= '0;
            victimQ <= '0;
            cntQ    <= '0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    ageArr[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state <= stateN;
            if (accept) begin
                addrQ   <= bus.req_addr;
                wdataQ  <= bus.req_wdata;
                victimQ <= victim;
                cntQ    <= '0;
                respQ   <= (!bus.req_write && hit) ? hitWord
                                                   : '0;
            end
            if (fillBeat && cntQ != LAST) begin
                cntQ <= cntQ + WIB'(1);
            end
            if (state == FILL_DONE) begin
                validArr[setQ][victimQ] <= 1'b1;
                respQ <= dataArr[victimQ][setQ][wordQ];
            end
            if (lruEn) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (ageArr[lruSet][w] <
                        ageArr[lruSet][lruWay]) begin
                        ageArr[lruSet][w] <=
                            ageArr[lruSet][w] + WAY_W'(1);
                    end
                end
                ageArr[lruSet][lruWay] <= '0;
            end
        end
    end

    // Storage arrays carry no reset; validity alone gates use.
    always_ff @(posedge clk) begin
        if (accept && bus.req_write && hit) begin
            dataArr[hitWay][reqSet][reqWord] <= bus.req_wdata;
        end
        if (fillBeat) begin
            dataArr[victimQ][setQ][cntQ] <= bus.mem_resp_data;
        end
        if (state == FILL_DONE) begin
            tagArr[victimQ][setQ] <= tagOf(addrQ);
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.miss          = accept & ~hit;
    assign bus.resp_valid    = (state == RESP);
    assign bus.resp_rdata    = (state == RESP) ? respQ : '0;
    assign bus.mem_req_valid = (state == FILL_REQ)
                             | (state == WR_MEM);
    assign bus.mem_req_write = (state == WR_MEM);
    assign bus.mem_req_addr  =
        (state == FILL_REQ) ? fillAddr :
        (state == WR_MEM)   ? wordAddr : '0;
    assign bus.mem_req_wdata =
        (state == WR_MEM) ? wdataQ : '0;
endmodule
